// File: rtl/instr_encoder_pkg.sv
// Shared instruction-set constants for the MIPS encoder and the CTRL decoder.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
// Contents: mnemonic codes, opcode/funct values, illegal-code boundary, FIFO entry type.
package instr_encoder_pkg;

  // Symbolic mnemonic codes presented on in_mnem
  localparam logic [3:0] MN_NOP  = 4'd0;
  localparam logic [3:0] MN_ADD  = 4'd1;
  localparam logic [3:0] MN_SUB  = 4'd2;
  localparam logic [3:0] MN_SUBP = 4'd3;
  localparam logic [3:0] MN_ORI  = 4'd4;
  localparam logic [3:0] MN_LW   = 4'd5;
  localparam logic [3:0] MN_SW   = 4'd6;
  localparam logic [3:0] MN_BEQ  = 4'd7;
  localparam logic [3:0] MN_LUI  = 4'd8;
  localparam logic [3:0] MN_JAL  = 4'd9;
  localparam logic [3:0] MN_JR   = 4'd10;
  localparam logic [3:0] MN_J    = 4'd11;

  // First code with no instruction behind it; everything at or above is illegal
  localparam logic [3:0] MN_ILLEGAL_MIN = 4'd12;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  // R-type funct values
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBP = 6'b110001;
  localparam logic [5:0] FN_JR   = 6'b001000;

  // One output-buffer slot: machine word, its IM byte address, illegal flag
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
    logic        err;
  } enc_entry_t;

endpackage

// File: rtl/instr_enc_comb.sv
// Purely combinational mnemonic+fields to 32-bit MIPS word; usable as a golden model.
// Latency: 0 cycles (combinational).
// Backpressure: none, no state.
// Ports: mnem/rs/rt/rd/imm/target in; instr (machine word) and err (illegal code) out.
module instr_enc_comb
  import instr_encoder_pkg::*;
(
  input  logic [3:0]  mnem,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] instr,
  output logic        err
);

  always_comb begin
    instr = 32'h0000_0000;
    err   = (mnem >= MN_ILLEGAL_MIN);
    // Each arm builds only the fields its format uses, so unused inputs never leak in.
    case (mnem)
      MN_ADD:  instr = {OP_RTYPE, rs, rt, rd, 5'd0, FN_ADD};
      MN_SUB:  instr = {OP_RTYPE, rs, rt, rd, 5'd0, FN_SUB};
      MN_SUBP: instr = {OP_RTYPE, rs, rt, rd, 5'd0, FN_SUBP};
      MN_JR:   instr = {OP_RTYPE, rs, 5'd0, 5'd0, 5'd0, FN_JR};
      MN_ORI:  instr = {OP_ORI, rs, rt, imm};
      MN_LW:   instr = {OP_LW,  rs, rt, imm};
      MN_SW:   instr = {OP_SW,  rs, rt, imm};
      MN_BEQ:  instr = {OP_BEQ, rs, rt, imm};
      MN_LUI:  instr = {OP_LUI, 5'd0, rt, imm};
      MN_J:    instr = {OP_J,   target};
      MN_JAL:  instr = {OP_JAL, target};
      default: instr = 32'h0000_0000;  // NOP and illegal codes both emit zero
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Streams symbolic instruction requests out as addressed 32-bit MIPS words.
// Latency: accept on edge N -> out_valid visible after edge N when the buffer was empty.
// Backpressure: 2-entry output buffer; in_ready drops only when both slots are full.
// Ports: clk, reset (async, active low); in_* request stream (valid/ready);
//        out_* word stream (valid/ready) with addr and err; word_cnt saturating accept count.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000,
  parameter int          IM_WORDS  = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_mnem,
  input  logic [4:0]  in_rs,
  input  logic [4:0]  in_rt,
  input  logic [4:0]  in_rd,
  input  logic [15:0] in_imm,
  input  logic [25:0] in_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        out_err,
  output logic [15:0] word_cnt
);

  // IM_WORDS is a power of two, so the index wraps by natural overflow.
  localparam int IDX_W = $clog2(IM_WORDS);

  logic [31:0]      enc_instr;
  logic             enc_err;
  logic [IDX_W-1:0] idx;
  enc_entry_t       slot [0:1];
  enc_entry_t       head;
  logic             rd_ptr;
  logic             wr_ptr;
  logic [1:0]       count;
  logic             push;
  logic             pop;

  instr_enc_comb u_enc (
    .mnem   (in_mnem),
    .rs     (in_rs),
    .rt     (in_rt),
    .rd     (in_rd),
    .imm    (in_imm),
    .target (in_target),
    .instr  (enc_instr),
    .err    (enc_err)
  );

  // Gating with reset keeps in_ready low during reset and high on the first
  // cycle after release; otherwise it follows only the registered fill level.
  assign in_ready  = reset && (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign head      = slot[rd_ptr];
  assign out_instr = head.instr;
  assign out_addr  = head.addr;
  assign out_err   = head.err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // Slots are cleared so the idle output shows word 0 at BASE_ADDR.
      slot[0]  <= '{instr: 32'h0, addr: BASE_ADDR, err: 1'b0};
      slot[1]  <= '{instr: 32'h0, addr: BASE_ADDR, err: 1'b0};
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      count    <= 2'd0;
      idx      <= '0;
      word_cnt <= 16'd0;
    end else begin
      if (push) begin
        slot[wr_ptr] <= '{instr: enc_instr,
                          addr:  BASE_ADDR + 32'({idx, 2'b00}),
                          err:   enc_err};
        wr_ptr <= ~wr_ptr;
        idx    <= idx + IDX_W'(1);
        if (word_cnt != 16'hFFFF) begin
          word_cnt <= word_cnt + 16'd1;
        end
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      // Push with pop at count 1 leaves the level unchanged; push at count 2 cannot happen.
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: doc/instr_encoder.md
Name: instr_encoder

Overview:
- Inverse of the CPU's control decoder: accepts symbolic instruction requests (mnemonic code plus register and immediate fields) and emits 32-bit MIPS machine words, each tagged with its instruction-memory address.
- Sits in the test/loader infrastructure in front of the IM loader, so benches generate programs without hand-assembled hex.
- Valid/ready streaming on both sides, with a 2-entry output buffer so a stalled IM loader does not throttle the request source immediately.

Parameters:
- BASE_ADDR, 32'h0000_3000, address of the first emitted word.
- IM_WORDS, 4096, IM depth in words; the address index wraps at this value (must be a power of 2, at least 2).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted at 0).
- in_valid  in  1  request present.
- in_ready  out  1  encoder can accept a request.
- in_mnem  in  4  mnemonic code (see Behaviour).
- in_rs  in  5  rs field.
- in_rt  in  5  rt field.
- in_rd  in  5  rd field.
- in_imm  in  16  immediate for ori/lw/sw/beq/lui.
- in_target  in  26  jump target for j/jal.
- out_valid  out  1  head word valid.
- out_ready  in  1  consumer accepts the head word.
- out_instr  out  32  encoded machine word.
- out_addr  out  32  IM byte address of out_instr.
- out_err  out  1  head word came from an illegal mnemonic.
- word_cnt  out  16  total words accepted since reset (saturates at 16'hFFFF).

Behaviour:
- Mnemonic codes: 0 NOP, 1 ADD, 2 SUB, 3 SUBP, 4 ORI, 5 LW, 6 SW, 7 BEQ, 8 LUI, 9 JAL, 10 JR, 11 J. Codes 12-15 are illegal.
- Encodings:
  - R-type: op 000000, shamt 0. Funct: ADD 100000, SUB 100010, SUBP 110001, JR 001000.
  - I-type opcodes: ORI 001101, LW 100011, SW 101011, BEQ 000100, LUI 001111.
  - J-type opcodes: J 000010, JAL 000011.
- Unused fields are forced to zero regardless of input:
  - JR: rt and rd zeroed.
  - LUI: rs zeroed.
  - I-type: rd ignored.
  - J-type: only the target is used.
  - NOP: word is 32'h0000_0000.
- Illegal mnemonic: word is 32'h0, out_err=1. It still consumes an address slot and increments word_cnt.
- Accept occurs when in_valid && in_ready. On accept, the encoded word, address and error flag are written into the 2-entry FIFO.
  - Latency: accept on edge N gives out_valid=1 after edge N (visible in cycle N+1) if the FIFO was empty.
  - Combinational encode, registered storage; no combinational path from in_* to out_*.
- in_ready = (fifo_count < 2). It depends only on registered state, never on out_ready.
- Pop occurs when out_valid && out_ready. Simultaneous push and pop with count=2 is impossible because in_ready=0. With count=1, a simultaneous push and pop leaves the count unchanged and preserves order.
- Address generation: a register idx starts at 0 and increments on each accept, modulo IM_WORDS. out_addr = BASE_ADDR + 4*idx latched at accept. After IM_WORDS accepts, the next address returns to BASE_ADDR.
- word_cnt increments on each accept and holds at 16'hFFFF.
- Outputs hold stable while out_valid && !out_ready.
- Reset (asynchronous, any time including mid-transfer) sets:
  - FIFO empty, out_valid=0, out_instr=0, out_addr=BASE_ADDR, out_err=0.
  - idx=0, word_cnt=0.
  - in_ready=0 while reset is asserted, 1 in the first cycle after deassertion.
  - In-flight words are discarded.

Decomposition:
- Shared package: mnemonic code constants, opcode constants (OP_ORI, OP_LW, ...), funct constants (FN_ADD, FN_SUB, FN_SUBP, FN_JR), and the illegal-code boundary. These are the same constants the CTRL decoder compares against, so encoder and decoder share one source.
- Sub-module: instr_enc_comb, a purely combinational mnemonic+fields to {instr, err} function, reusable by benches as a golden model. The top module holds the FIFO, the idx counter and word_cnt.

Test Plan:
- ADD rs=1 rt=2 rd=3, out_ready=1 -> out_instr=32'h0022_1820, out_addr=32'h3000, out_err=0, one cycle after accept.
- Stream ORI rs=0 rt=1 imm=16'h1234, LW rs=2 rt=3 imm=16'hFFFC, SUBP rs=1 rt=2 rd=3, JR rs=31 rd=5, JAL target=26'h0000C03:
  - instr: 32'h3401_1234, 32'h8C43_FFFC, 32'h0022_1831, 32'h03E0_0008 (rd masked), 32'h0C00_0C03.
  - addresses: 3000, 3004, 3008, 300C, 3010.
- Backpressure: out_ready=0, push three requests -> in_ready falls after the 2nd accept and the 3rd is held. Raise out_ready -> all three emerge in order with consecutive addresses; word_cnt=3.
- Illegal mnem=13 between two NOPs -> words 0, 0, 0; out_err pattern 0, 1, 0; addresses 3000, 3004, 3008.
- IM_WORDS=4, five accepts -> the fifth out_addr=32'h3000.
- Assert reset with 2 words buffered -> out_valid=0 immediately (asynchronous). After release, the next accept gets addr 32'h3000 and word_cnt=1.
